// File: rtl/layer7_operand_sequencer_if.sv
// Bus between the layer-7 operand sequencer and its environment: scheduler
// handshake, input/weight/bias SRAM read ports, MAC operand/result lines and
// the result-buffer write port.
//   master : sequencer side (drives addresses, operands, result writes)
//   slave  : environment side (SRAMs, MAC, scheduler)
interface layer7_operand_sequencer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] in_addr;
    logic [127:0]      in_rdata;
    logic [ADDR_W-1:0] w_addr;
    logic [127:0]      w_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic [15:0]       b_rdata;
    logic              mac_clr;
    logic [127:0]      mac_input;
    logic [127:0]      mac_weight;
    logic [15:0]       mac_bias;
    logic [15:0]       mac_result;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [15:0]       res_data;

    modport master (
        input  start, in_rdata, w_rdata, b_rdata, mac_result,
        output busy, done, in_addr, w_addr, b_addr, mac_clr, mac_input, mac_weight,
               mac_bias, res_we, res_addr, res_data
    );

    modport slave (
        output start, in_rdata, w_rdata, b_rdata, mac_result,
        input  busy, done, in_addr, w_addr, b_addr, mac_clr, mac_input, mac_weight,
               mac_bias, res_we, res_addr, res_data
    );
endinterface

// File: rtl/layer7_operand_sequencer.sv
// Layer-7 fully connected operand sequencer. For each output neuron j it clears
// the MAC, streams IN_WORDS input/weight word pairs from 1-cycle-latency SRAMs
// into the 8-lane MAC, supplies the neuron bias and writes the biased result.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : layer7_operand_sequencer_if.master (handshake, SRAM ports, MAC, result)
module layer7_operand_sequencer #(
    parameter int unsigned IN_WORDS    = 8,
    parameter int unsigned OUT_NEURONS = 10,
    parameter int unsigned ADDR_W      = 10
) (
    input logic                        clk,
    input logic                        rst,
    layer7_operand_sequencer_if.master bus
);
    localparam int unsigned KW = $clog2(IN_WORDS + 1);
    localparam logic [KW-1:0]     KLast   = KW'(IN_WORDS);
    localparam logic [ADDR_W-1:0] JLast   = ADDR_W'(OUT_NEURONS - 1);
    localparam logic [ADDR_W-1:0] WStride = ADDR_W'(IN_WORDS);

    typedef enum logic [1:0] {StIdle, StClr, StFeed, StWrite} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;     // j * IN_WORDS, kept incrementally
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              done_q, done_d;
    logic              issue;
    logic              feed;
    logic              we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            j_q       <= '0;
            wbase_q   <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            wbase_q   <= wbase_d;
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        wbase_d = wbase_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        feed    = 1'b0;
        we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start landing on the done cycle belongs to the finished run.
                if (bus.start && !done_q) begin
                    j_d     = '0;
                    k_d     = '0;
                    wbase_d = '0;
                    state_d = StClr;
                end
            end
            StClr: begin
                issue   = 1'b1;
                state_d = StFeed;
            end
            StFeed: begin
                feed = 1'b1;
                // Data from the previous address arrives now; the final FEED
                // cycle only consumes.
                if (k_q != KLast) begin
                    issue = 1'b1;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                we = 1'b1;
                if (j_q != JLast) begin
                    j_d     = j_q + ADDR_W'(1);
                    wbase_d = wbase_q + WStride;
                    k_d     = '0;
                    state_d = StClr;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            k_d = k_q + KW'(1);
        end

        // Addresses are live in the issuing cycle and hold otherwise.
        in_addr_d = issue ? ADDR_W'(k_q) : in_addr_q;
        w_addr_d  = issue ? wbase_q + ADDR_W'(k_q) : w_addr_q;

        bus.busy       = (state_q != StIdle);
        bus.done       = done_q;
        bus.in_addr    = in_addr_d;
        bus.w_addr     = w_addr_d;
        bus.b_addr     = j_q;
        bus.mac_clr    = (state_q == StClr);
        // Zero operands outside FEED keep the accumulator unchanged.
        bus.mac_input  = feed ? bus.in_rdata : '0;
        bus.mac_weight = feed ? bus.w_rdata : '0;
        bus.mac_bias   = (state_q != StIdle) ? bus.b_rdata : '0;
        bus.res_we     = we;
        bus.res_addr   = j_q;
        bus.res_data   = we ? bus.mac_result : '0;
    end
endmodule

// File: tb/tb_layer7_operand_sequencer.sv
module tb_layer7_operand_sequencer;
    localparam int unsigned IN_WORDS    = 8;
    localparam int unsigned OUT_NEURONS = 10;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam int          BUSY_CYCLES = OUT_NEURONS * (IN_WORDS + 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer7_operand_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    layer7_operand_sequencer #(
        .IN_WORDS   (IN_WORDS),
        .OUT_NEURONS(OUT_NEURONS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    logic [127:0] in_mem [DEPTH];
    logic [127:0] w_mem  [DEPTH];
    logic [15:0]  b_mem  [DEPTH];

    int total = 0;
    int bad   = 0;

    logic [15:0]       got_data [$];
    logic [ADDR_W-1:0] got_addr [$];

    // 1-cycle-latency SRAM models
    always @(posedge clk) begin
        bus_if.in_rdata <= in_mem[bus_if.in_addr];
        bus_if.w_rdata  <= w_mem[bus_if.w_addr];
        bus_if.b_rdata  <= b_mem[bus_if.b_addr];
    end

    // Q6.10 lane product, scaled back to Q6.10
    function automatic logic signed [31:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] x, y;
        x = {{16{a[15]}}, a};
        y = {{16{b[15]}}, b};
        return (x * y) >>> 10;
    endfunction

    // MAC model: register accumulator, combinational biased result
    logic signed [31:0] acc;
    logic signed [31:0] lane_sum;
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < 8; l++) begin
            lane_sum = lane_sum + qmul(bus_if.mac_input[16*l +: 16], bus_if.mac_weight[16*l +: 16]);
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (bus_if.mac_clr) acc <= '0;
        else acc <= acc + lane_sum;
    end
    assign bus_if.mac_result = acc[15:0] + bus_if.mac_bias;

    // Reference: neuron j = sum over its input/weight words of lane products, plus bias
    function automatic logic [15:0] ref_result(input int j);
        longint s;
        logic [127:0] a, b;
        s = 0;
        for (int k = 0; k < IN_WORDS; k++) begin
            a = in_mem[k];
            b = w_mem[(j * IN_WORDS + k) % DEPTH];
            for (int l = 0; l < 8; l++) s += longint'(qmul(a[16*l +: 16], b[16*l +: 16]));
        end
        return 16'(s) + b_mem[j];
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},    bus_if.busy, 0);
        check_eq({tag, "_done"},    bus_if.done, 0);
        check_eq({tag, "_clr"},     bus_if.mac_clr, 0);
        check_eq({tag, "_we"},      bus_if.res_we, 0);
        check_eq({tag, "_in"},      bus_if.mac_input, 0);
        check_eq({tag, "_wt"},      bus_if.mac_weight, 0);
        check_eq({tag, "_bias"},    bus_if.mac_bias, 0);
        check_eq({tag, "_in_addr"}, bus_if.in_addr, 0);
        check_eq({tag, "_w_addr"},  bus_if.w_addr, 0);
        check_eq({tag, "_b_addr"},  bus_if.b_addr, 0);
        check_eq({tag, "_r_addr"},  bus_if.res_addr, 0);
        check_eq({tag, "_r_data"},  bus_if.res_data, 0);
    endtask

    task automatic fill_const(input logic [15:0] iv, input logic [15:0] wv);
        for (int i = 0; i < DEPTH; i++) begin
            in_mem[i] = {8{iv}};
            w_mem[i]  = {8{wv}};
            b_mem[i]  = '0;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            in_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            w_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
            b_mem[i]  = 16'($urandom);
        end
    endtask

    // Pulse start and observe the run at each negedge. Offset 1 is neuron 0's CLR.
    // rst_at > 0 asserts reset at that offset and ends the run there.
    task automatic run_layer(input string tag, input bit trace, input bit poke, input int rst_at);
        int nbusy, nclr, done_off, end_off;
        got_data.delete();
        got_addr.delete();
        nbusy    = 0;
        nclr     = 0;
        done_off = -1;
        end_off  = 400;
        bus_if.start = 1'b1;
        for (int off = 1; off <= end_off; off++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            if (off == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({tag, "_midrst"});
                return;
            end
            if (bus_if.res_we) begin
                got_data.push_back(bus_if.res_data);
                got_addr.push_back(bus_if.res_addr);
                check_eq({tag, "_wr_ops"}, {bus_if.mac_input, bus_if.mac_weight} == '0, 1);
            end
            if (bus_if.mac_clr) nclr++;
            if (bus_if.busy) nbusy++;
            if (trace && off >= 31 && off <= 38) begin
                check_eq({tag, "_w_addr"}, bus_if.w_addr, 24 + off - 31);
                check_eq({tag, "_in_addr"}, bus_if.in_addr, off - 31);
            end
            if (trace && off >= 31 && off <= 40) check_eq({tag, "_b_addr"}, bus_if.b_addr, 3);
            if (poke && off == 50) bus_if.start = 1'b1;
            if (bus_if.done && done_off < 0) begin
                done_off = off;
                end_off  = off + 30;
                if (poke) bus_if.start = 1'b1;
            end
        end
        check_eq({tag, "_done_at"}, done_off, BUSY_CYCLES + 1);
        check_eq({tag, "_busy_cyc"}, nbusy, BUSY_CYCLES);
        check_eq({tag, "_clr_cnt"}, nclr, OUT_NEURONS);
        check_eq({tag, "_wr_cnt"}, got_data.size(), OUT_NEURONS);
        for (int i = 0; i < got_data.size(); i++) begin
            check_eq({tag, "_res_addr"}, got_addr[i], i);
            check_eq({tag, "_res_data"}, got_data[i], ref_result(i));
        end
    endtask

    initial begin
        int idle_we;
        rst = 1'b1;
        bus_if.start = 1'b0;
        fill_const(16'h0200, 16'h0200);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        idle_we = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.res_we || bus_if.busy) idle_we++;
        end
        check_eq("idle_quiet", idle_we, 0);

        // Defaults: 64 products of 0.25 each -> 16.0 = 0x4000
        run_layer("dflt", 1'b1, 1'b0, 0);
        for (int i = 0; i < OUT_NEURONS; i++) check_eq("dflt_const", got_data[i], 16'h4000);

        fill_random();
        run_layer("rand", 1'b1, 1'b0, 0);

        // Bias only: zero weights, bias j*0x0400
        fill_random();
        for (int i = 0; i < DEPTH; i++) w_mem[i] = '0;
        for (int j = 0; j < OUT_NEURONS; j++) b_mem[j] = 16'(j * 16'h0400);
        run_layer("bias", 1'b0, 1'b0, 0);
        for (int j = 0; j < OUT_NEURONS; j++) check_eq("bias_const", got_data[j], j * 16'h0400);

        // Starts while busy and on the done cycle are ignored
        fill_random();
        run_layer("poke", 1'b0, 1'b1, 0);
        check_eq("poke_idle_after", bus_if.busy, 0);

        // Reset in FEED of neuron 5, then a clean rerun
        fill_random();
        run_layer("rst", 1'b0, 1'b0, 1 + 5 * (IN_WORDS + 2) + 3);
        repeat (2) @(negedge clk);
        check_reset_outputs("held_rst");
        rst = 1'b0;
        @(negedge clk);
        run_layer("rerun", 1'b1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
